// File: rtl/dcp_route_fifo_unit.sv
// Decoupled router: one input steered into RNUM per-output FIFOs; bad destinations dropped and counted.
// Optional multicast (Dst as bitmask) when DCP_ROUTE_MCAST_EN is defined.
module dcp_route_fifo_unit #(
    parameter int DW    = 8,
    parameter int AW    = 4,
    parameter int RNUM  = 4,
    parameter int DEPTH = 4,
    parameter int CW    = 16
) (
    input  logic                                iClk,
    input  logic                                iRst,
    input  logic                                iDcpIn_Vld,
    output logic                                iDcpIn_Rdy,
    input  logic [DW-1:0]                       iDcpIn_Pld,
    input  logic [AW-1:0]                       iDcpIn_Dst,
    output logic [RNUM-1:0]                     oDcpOut_Vld,
    input  logic [RNUM-1:0]                     oDcpOut_Rdy,
    output logic [RNUM*DW-1:0]                  oDcpOut_Pld,
    output logic [RNUM*AW-1:0]                  oDcpOut_Dst,
    output logic [RNUM*$clog2(DEPTH+1)-1:0]     oLevel,
    output logic                                oDropPulse,
    output logic [CW-1:0]                       oDropCnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam int EW = DW + AW;

    logic [EW-1:0] mem_q    [RNUM][DEPTH];
    logic [EW-1:0] mem_d    [RNUM][DEPTH];
    logic [PW-1:0] wr_ptr_q [RNUM];
    logic [PW-1:0] wr_ptr_d [RNUM];
    logic [PW-1:0] rd_ptr_q [RNUM];
    logic [PW-1:0] rd_ptr_d [RNUM];
    logic [LW-1:0] level_q  [RNUM];
    logic [LW-1:0] level_d  [RNUM];
    logic          drop_pulse_q, drop_pulse_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;

    logic [RNUM-1:0] sel_s;
    logic [RNUM-1:0] full_s;
    logic [RNUM-1:0] vld_s;
    logic [RNUM-1:0] push_s;
    logic [RNUM-1:0] pop_s;
    logic            accept_s;
    logic            drop_s;

    // Destination decode: an all-zero select means the beat is dropped.
    always_comb begin
        sel_s = '0;
`ifdef DCP_ROUTE_MCAST_EN
        sel_s = iDcpIn_Dst[RNUM-1:0];
`else
        for (int r = 0; r < RNUM; r++) begin
            if (32'(iDcpIn_Dst) == r) begin
                sel_s[r] = 1'b1;
            end else begin
                sel_s[r] = 1'b0;
            end
        end
`endif
    end

    // Flags come only from registered levels, so Rdy never sees oDcpOut_Rdy.
    always_comb begin
        full_s = '0;
        vld_s  = '0;
        for (int r = 0; r < RNUM; r++) begin
            full_s[r] = (level_q[r] == LW'(DEPTH));
            vld_s[r]  = (level_q[r] != '0);
        end
    end

    assign iDcpIn_Rdy = ~|(sel_s & full_s);
    assign accept_s   = iDcpIn_Vld & iDcpIn_Rdy;
    assign drop_s     = accept_s & (sel_s == '0);
    assign push_s     = sel_s & {RNUM{accept_s}};
    assign pop_s      = vld_s & oDcpOut_Rdy;

    // Per-FIFO storage, pointer and level next-state.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        for (int r = 0; r < RNUM; r++) begin
            if (push_s[r]) begin
                mem_d[r][wr_ptr_q[r]] = {iDcpIn_Pld, iDcpIn_Dst};
                wr_ptr_d[r]           = wr_ptr_q[r] + PW'(1);
            end else begin
                wr_ptr_d[r] = wr_ptr_q[r];
            end
            if (pop_s[r]) begin
                rd_ptr_d[r] = rd_ptr_q[r] + PW'(1);
            end else begin
                rd_ptr_d[r] = rd_ptr_q[r];
            end
            case ({push_s[r], pop_s[r]})
                2'b10:   level_d[r] = level_q[r] + LW'(1);
                2'b01:   level_d[r] = level_q[r] - LW'(1);
                default: level_d[r] = level_q[r];
            endcase
        end
    end

    // Drop pulse and saturating drop counter next-state.
    always_comb begin
        drop_pulse_d = drop_s;
        drop_cnt_d   = drop_cnt_q;
        if (drop_s && (drop_cnt_q != {CW{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + CW'(1);
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Control state registers; reset discards every queued beat.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            for (int r = 0; r < RNUM; r++) begin
                wr_ptr_q[r] <= '0;
                rd_ptr_q[r] <= '0;
                level_q[r]  <= '0;
            end
            drop_pulse_q <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            drop_pulse_q <= drop_pulse_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // Payload storage needs no reset: entries are only visible through level.
    always_ff @(posedge iClk) begin
        mem_q <= mem_d;
    end

    for (genvar r = 0; r < RNUM; r++) begin : g_out
        logic [EW-1:0] head_s;
        assign head_s                  = mem_q[r][rd_ptr_q[r]];
        assign oDcpOut_Pld[r*DW +: DW] = head_s[EW-1:AW];
        assign oDcpOut_Dst[r*AW +: AW] = head_s[AW-1:0];
        assign oLevel[r*LW +: LW]      = level_q[r];
    end

    assign oDcpOut_Vld = vld_s;
    assign oDropPulse  = drop_pulse_q;
    assign oDropCnt    = drop_cnt_q;

endmodule

// File: tb/tb_dcp_route_fifo_unit.sv
// Directed bench for dcp_route_fifo_unit; CW shrunk to 4 so counter saturation is reachable.
module tb_dcp_route_fifo_unit;

    localparam int DW = 8, AW = 4, RNUM = 4, DEPTH = 4, CW = 4, LW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_vld, in_rdy;
    logic [DW-1:0]     in_pld;
    logic [AW-1:0]     in_dst;
    logic [RNUM-1:0]   out_vld, out_rdy;
    logic [RNUM*DW-1:0] out_pld;
    logic [RNUM*AW-1:0] out_dst;
    logic [RNUM*LW-1:0] level;
    logic              drop_pulse;
    logic [CW-1:0]     drop_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    dcp_route_fifo_unit #(.DW(DW), .AW(AW), .RNUM(RNUM), .DEPTH(DEPTH), .CW(CW)) dut (
        .iClk(clk), .iRst(rst),
        .iDcpIn_Vld(in_vld), .iDcpIn_Rdy(in_rdy), .iDcpIn_Pld(in_pld), .iDcpIn_Dst(in_dst),
        .oDcpOut_Vld(out_vld), .oDcpOut_Rdy(out_rdy), .oDcpOut_Pld(out_pld), .oDcpOut_Dst(out_dst),
        .oLevel(level), .oDropPulse(drop_pulse), .oDropCnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lvl(input int r);
        return 32'(level[r*LW +: LW]);
    endfunction

    function automatic logic [31:0] pld(input int r);
        return 32'(out_pld[r*DW +: DW]);
    endfunction

    function automatic logic [31:0] dst(input int r);
        return 32'(out_dst[r*AW +: AW]);
    endfunction

    initial begin
        int per [RNUM];
        int recv[RNUM];
        int sent;
        per = '{1, 2, 5, 10};
        recv = '{0, 0, 0, 0};

        rst = 1'b1; in_vld = 1'b0; in_pld = 8'h00; in_dst = 4'h0; out_rdy = 4'b0000;
        repeat (5) tick();
        rst = 1'b0;
        tick();
        check("reset_vld", 32'(out_vld), 32'h0);
        check("reset_level", 32'(level), 32'h0);
        check("reset_dropcnt", 32'(drop_cnt), 32'h0);
        check("reset_droppulse", 32'(drop_pulse), 32'h0);
        in_dst = 4'h0; #1;
        check("reset_rdy_dst0", 32'(in_rdy), 32'h1);

`ifndef DCP_ROUTE_MCAST_EN
        // Round-robin stream with outputs throttled at different periods
        sent = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int r = 0; r < RNUM; r++) out_rdy[r] = ((cyc / per[r]) % 2) == 0;
            in_vld = (sent < 16);
            in_dst = 4'(sent % 4);
            in_pld = 8'(sent % 4);
            #1;
            for (int r = 0; r < RNUM; r++) begin
                if (out_vld[r] && out_rdy[r]) begin
                    check("rr_pld", pld(r), 32'(r));
                    check("rr_dst", dst(r), 32'(r));
                    recv[r]++;
                end
            end
            if (in_vld && in_rdy) sent++;
            tick();
            if (sent == 16 && recv[0] + recv[1] + recv[2] + recv[3] == 16) break;
        end
        in_vld = 1'b0;
        for (int r = 0; r < RNUM; r++) check("rr_count", 32'(recv[r]), 32'd4);
        check("rr_level_empty", 32'(level), 32'h0);

        // Head-of-line isolation: output 3 stalled
        out_rdy = 4'b0111;
        for (int k = 0; k < 4; k++) begin
            in_vld = 1'b1; in_dst = 4'd3; in_pld = 8'(8'h30 + k); #1;
            check("hol_rdy_fill3", 32'(in_rdy), 32'h1);
            tick();
        end
        in_pld = 8'h34; #1;
        check("hol_rdy_full3", 32'(in_rdy), 32'h0);
        check("hol_level3", lvl(3), 32'd4);
        check("hol_head3", pld(3), 32'h30);
        for (int k = 0; k < 4; k++) begin
            in_dst = 4'd0; in_pld = 8'(8'hA0 + k); #1;
            check("hol_rdy_dst0", 32'(in_rdy), 32'h1);
            tick();
            check("hol_vld0", 32'(out_vld[0]), 32'h1);
            check("hol_pld0", pld(0), 32'(8'hA0 + k));
        end
        in_vld = 1'b0;
        tick();
        check("hol_vld0_idle", 32'(out_vld[0]), 32'h0);
        check("hol_level3_held", lvl(3), 32'd4);

        // Full FIFO refuses push even while being popped
        out_rdy = 4'b1000;
        repeat (4) tick();
        check("drain3_level", lvl(3), 32'd0);
        out_rdy = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            in_vld = 1'b1; in_dst = 4'd1; in_pld = 8'(8'h10 + k);
            tick();
        end
        check("full1_level", lvl(1), 32'd4);
        in_pld = 8'h14; out_rdy = 4'b0010; #1;
        check("full1_rdy_on_pop", 32'(in_rdy), 32'h0);
        tick();
        check("full1_level_after_pop", lvl(1), 32'd3);
        check("full1_head_after_pop", pld(1), 32'h11);
        out_rdy = 4'b0000; #1;
        check("full1_rdy_next", 32'(in_rdy), 32'h1);
        tick();
        in_vld = 1'b0;
        check("full1_level_refill", lvl(1), 32'd4);
        out_rdy = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("full1_order", pld(1), 32'(8'h11 + k));
            check("full1_dst", dst(1), 32'd1);
            tick();
        end
        out_rdy = 4'b0000;
        check("full1_empty", lvl(1), 32'd0);

        // Out-of-range destinations are dropped and counted
        in_vld = 1'b1; in_dst = 4'd7; in_pld = 8'h77; #1;
        check("drop_rdy7", 32'(in_rdy), 32'h1);
        tick();
        check("drop_pulse7", 32'(drop_pulse), 32'h1);
        check("drop_cnt7", 32'(drop_cnt), 32'd1);
        in_dst = 4'd15; #1;
        check("drop_rdy15", 32'(in_rdy), 32'h1);
        tick();
        check("drop_pulse15", 32'(drop_pulse), 32'h1);
        check("drop_cnt15", 32'(drop_cnt), 32'd2);
        check("drop_no_vld", 32'(out_vld), 32'h0);
        in_vld = 1'b0;
        tick();
        check("drop_pulse_off", 32'(drop_pulse), 32'h0);
        check("drop_cnt_hold", 32'(drop_cnt), 32'd2);
        in_vld = 1'b1; in_dst = 4'd9;
        repeat (15) tick();
        check("drop_cnt_sat", 32'(drop_cnt), 32'hF);
        check("drop_pulse_sat", 32'(drop_pulse), 32'h1);
        in_vld = 1'b0;
        tick();
        check("drop_cnt_sat_hold", 32'(drop_cnt), 32'hF);

        // Reset mid-operation discards queued beats
        in_vld = 1'b1; in_dst = 4'd0; in_pld = 8'h5A;
        repeat (2) tick();
        in_vld = 1'b0;
        check("midrst_pre_level0", lvl(0), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("midrst_vld", 32'(out_vld), 32'h0);
        check("midrst_level0", lvl(0), 32'd0);
        check("midrst_dropcnt", 32'(drop_cnt), 32'd0);
`else
        // Multicast: all selected FIFOs must have room
        out_rdy = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            in_vld = 1'b1; in_dst = 4'b0100; in_pld = 8'(8'h20 + k);
            tick();
        end
        check("mc_level2", lvl(2), 32'd4);
        in_dst = 4'b0101; in_pld = 8'h55; #1;
        check("mc_rdy_blocked", 32'(in_rdy), 32'h0);
        out_rdy = 4'b0100;
        tick();
        out_rdy = 4'b0000; #1;
        check("mc_rdy_open", 32'(in_rdy), 32'h1);
        tick();
        in_vld = 1'b0;
        check("mc_level0", lvl(0), 32'd1);
        check("mc_level2_after", lvl(2), 32'd4);
        check("mc_pld0", pld(0), 32'h55);
        out_rdy = 4'b0100;
        repeat (3) tick();
        out_rdy = 4'b0000;
        check("mc_pld2", pld(2), 32'h55);
        check("mc_pld0_same", pld(0), 32'h55);
        check("mc_vld", 32'(out_vld), 32'b0101);
        in_vld = 1'b1; in_dst = 4'b0000; #1;
        check("mc_rdy_mask0", 32'(in_rdy), 32'h1);
        tick();
        in_vld = 1'b0;
        check("mc_drop_pulse", 32'(drop_pulse), 32'h1);
        check("mc_drop_cnt", 32'(drop_cnt), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
